// File: rtl/viterbi_decoder_k3.sv
// viterbi_decoder_k3
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) convolutional code.
//   Four-state add-compare-select with register-exchange survivors; the decoded bit
//   for symbol k is strobed one cycle after symbol k+TB_DEPTH-1 is accepted.
//
//   Optional build macro: VIT_ERRCNT_EN enables the best-path distance counter on err_cnt;
//   without it err_cnt is tied to zero.
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   start      synchronous restart pulse (priority over in_valid, same-cycle symbol is kept)
//   in_valid   rx_par carries a symbol this cycle
//   rx_par     received parity pair {p1,p0}
//   out_bit    decoded information bit
//   out_valid  single-cycle strobe qualifying out_bit
//   err_cnt    accumulated best-path Hamming distance (saturating, 16 bit)

module viterbi_decoder_k3 #(
    parameter int unsigned TB_DEPTH = 15,
    parameter int unsigned MW       = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        in_valid,
    input  logic [1:0]  rx_par,
    output logic        out_bit,
    output logic        out_valid,
    output logic [15:0] err_cnt
);

    localparam int unsigned   CW      = $clog2(TB_DEPTH + 1);
    localparam logic [MW-1:0] PmMax   = '1;
    localparam logic [CW-1:0] CntFull = CW'(TB_DEPTH);
    localparam logic [CW-1:0] CntOut  = CW'(TB_DEPTH - 1);

    logic [MW-1:0]       pm_q [4];
    logic [MW-1:0]       pm_d [4];
    logic [MW-1:0]       pm_cur [4];
    logic [MW-1:0]       pm_acs [4];
    logic [MW-1:0]       pm_norm [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [TB_DEPTH-1:0] surv_cur [4];
    logic [TB_DEPTH-1:0] surv_acs [4];
    logic [CW-1:0]       cnt_q, cnt_d, cnt_cur;
    logic                out_bit_q, out_bit_d;
    logic                out_valid_q, out_valid_d;
    logic [MW-1:0]       pm_min;
    logic [1:0]          best;

    // Hamming distance between rx and the pair the encoder emits from state s on input b.
    function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic b,
                                                 input logic [1:0] rx);
        logic [1:0] d;
        d = rx ^ {b ^ s[0] ^ s[1], b ^ s[1]};
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

    function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [1:0] b);
        logic [MW:0] s;
        s = {1'b0, a} + (MW + 1)'(b);
        return s[MW] ? PmMax : s[MW-1:0];
    endfunction

    // start re-initialises the working copy, so a same-cycle symbol sees the fresh state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pm_cur[i]   = start ? ((i == 0) ? '0 : PmMax) : pm_q[i];
            surv_cur[i] = start ? '0 : surv_q[i];
        end
        cnt_cur = start ? '0 : cnt_q;
    end

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] Ns = 2'(g);
        localparam logic [1:0] P0 = {1'b0, Ns[1]};
        localparam logic [1:0] P1 = {1'b1, Ns[1]};
        logic [MW-1:0]       cand0, cand1;
        logic                sel;
        logic [TB_DEPTH-1:0] win;

        assign cand0 = sat_add(pm_cur[P0], branch_metric(P0, Ns[0], rx_par));
        assign cand1 = sat_add(pm_cur[P1], branch_metric(P1, Ns[0], rx_par));
        // Strict compare: ties go to the predecessor with u2=0.
        assign sel         = cand1 < cand0;
        assign pm_acs[g]   = sel ? cand1 : cand0;
        assign win         = sel ? surv_cur[P1] : surv_cur[P0];
        assign surv_acs[g] = {win[TB_DEPTH-2:0], Ns[0]};
    end

    // Best state: lowest metric, lowest index on ties.
    always_comb begin
        pm_min = pm_acs[0];
        best   = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm_acs[i] < pm_min) begin
                pm_min = pm_acs[i];
                best   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pm_norm[i] = (pm_acs[i] == PmMax) ? PmMax : pm_acs[i] - pm_min;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pm_d[i]   = pm_q[i];
            surv_d[i] = surv_q[i];
        end
        cnt_d       = cnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        if (start) begin
            for (int i = 0; i < 4; i++) begin
                pm_d[i]   = pm_cur[i];
                surv_d[i] = surv_cur[i];
            end
            cnt_d     = '0;
            out_bit_d = 1'b0;
        end
        if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                pm_d[i]   = pm_norm[i];
                surv_d[i] = surv_acs[i];
            end
            cnt_d = (cnt_cur == CntFull) ? cnt_cur : cnt_cur + CW'(1);
            if (cnt_cur >= CntOut) begin
                out_valid_d = 1'b1;
                out_bit_d   = surv_acs[best][TB_DEPTH-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PmMax;
                surv_q[i] <= '0;
            end
            cnt_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;

    // The oldest survivor bit is shifted out by the exchange and never read.
    logic unused_surv_msb;
    assign unused_surv_msb = surv_cur[0][TB_DEPTH-1] ^ surv_cur[1][TB_DEPTH-1]
                           ^ surv_cur[2][TB_DEPTH-1] ^ surv_cur[3][TB_DEPTH-1];

`ifdef VIT_ERRCNT_EN
    logic [15:0] err_q, err_d;
    logic [16:0] err_sum;

    // Pre-normalisation minimum is the best-path distance added by this symbol.
    always_comb begin
        err_d   = err_q;
        err_sum = {1'b0, (start ? 16'h0000 : err_q)} + 17'(pm_min);
        if (start) begin
            err_d = 16'h0000;
        end
        if (in_valid) begin
            err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 16'h0000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
module tb_viterbi_decoder_k3;

    localparam int TbDepth = 15;
`ifdef VIT_ERRCNT_EN
    localparam bit ErrCntEn = 1'b1;
`else
    localparam bit ErrCntEn = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic        in_valid;
    logic [1:0]  rx_par;
    logic        out_bit;
    logic        out_valid;
    logic [15:0] err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    viterbi_decoder_k3 #(
        .TB_DEPTH (TbDepth),
        .MW       (6)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .in_valid  (in_valid),
        .rx_par    (rx_par),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .err_cnt   (err_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output collector, sampled 1 time unit after each rising edge.
    bit   mon_q[$];
    int   nsym;
    int   first_sym;
    int   idle_strobes;
    logic mon_iv;

    always begin
        @(posedge CLK);
        mon_iv = in_valid;
        #1;
        if (mon_iv && RST_N) nsym++;
        if (out_valid) begin
            if (first_sym < 0) first_sym = nsym;
            if (!mon_iv) idle_strobes++;
            mon_q.push_back(out_bit);
        end
    end

    // Reference encoder shift register (u1 newest past bit, u2 oldest).
    logic enc_u1, enc_u2;

    logic [1:0] clean_rx [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    task automatic clear_mon();
        mon_q.delete();
        nsym         = 0;
        first_sym    = -1;
        idle_strobes = 0;
    endtask

    task automatic send_sym(input logic [1:0] p, input logic st);
        @(negedge CLK);
        start    = st;
        in_valid = 1'b1;
        rx_par   = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            start    = 1'b0;
            in_valid = 1'b0;
            rx_par   = 2'b00;
        end
    endtask

    task automatic send_bit(input logic b, input logic [1:0] flip, input logic st);
        logic [1:0] p;
        if (st) begin
            enc_u1 = 1'b0;
            enc_u2 = 1'b0;
        end
        p      = {b ^ enc_u1 ^ enc_u2, b ^ enc_u2} ^ flip;
        enc_u2 = enc_u1;
        enc_u1 = b;
        send_sym(p, st);
    endtask

    // 6 directed symbols then 30 zero symbols; first symbol restarts the decoder.
    task automatic run_ref(input int flip_idx, input int gap_max);
        logic [1:0] p;
        clear_mon();
        for (int i = 0; i < 36; i++) begin
            p = (i < 6) ? clean_rx[i] : 2'b00;
            if (i == flip_idx) p = 2'b10;
            send_sym(p, i == 0);
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
        idle(3);
    endtask

    function automatic logic [63:0] pack_out();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < mon_q.size() && i < 64; i++) v[i] = mon_q[i];
        return v;
    endfunction

    task automatic test_reset();
        RST_N    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        rx_par   = 2'b00;
        repeat (3) @(negedge CLK);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_bit !== 1'b0) $display("FAIL reset_out_bit: got %b want 0", out_bit);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'h0) $display("FAIL reset_err_cnt: got %h want 0000", err_cnt);
        else n_pass++;
        n_total++;
        if (dut.pm_q[0] !== 6'd0) $display("FAIL reset_pm0: got %0d want 0", dut.pm_q[0]);
        else n_pass++;
        n_total++;
        if (dut.pm_q[3] !== 6'd63) $display("FAIL reset_pm3: got %0d want 63", dut.pm_q[3]);
        else n_pass++;
        RST_N = 1'b1;
        idle(2);
    endtask

    task automatic test_clean();
        run_ref(-1, 0);
        n_total++;
        if (mon_q.size() != 22) $display("FAIL clean_count: got %0d want 22", mon_q.size());
        else n_pass++;
        n_total++;
        if (pack_out() !== 64'hD) $display("FAIL clean_bits: got %h want %h", pack_out(), 64'hD);
        else n_pass++;
        n_total++;
        if (first_sym != TbDepth)
            $display("FAIL clean_latency: got %0d want %0d", first_sym, TbDepth);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'h0) $display("FAIL clean_err_cnt: got %h want 0000", err_cnt);
        else n_pass++;
        n_total++;
        if (idle_strobes != 0) $display("FAIL clean_idle_strobe: got %0d want 0", idle_strobes);
        else n_pass++;
    endtask

    task automatic test_single_error();
        logic [15:0] exp_err;
        exp_err = ErrCntEn ? 16'd1 : 16'd0;
        run_ref(2, 0);
        n_total++;
        if (mon_q.size() != 22) $display("FAIL serr_count: got %0d want 22", mon_q.size());
        else n_pass++;
        n_total++;
        if (pack_out() !== 64'hD) $display("FAIL serr_bits: got %h want %h", pack_out(), 64'hD);
        else n_pass++;
        n_total++;
        if (err_cnt !== exp_err) $display("FAIL serr_err_cnt: got %h want %h", err_cnt, exp_err);
        else n_pass++;
    endtask

    task automatic test_gapped();
        run_ref(-1, 7);
        n_total++;
        if (mon_q.size() != 22) $display("FAIL gap_count: got %0d want 22", mon_q.size());
        else n_pass++;
        n_total++;
        if (pack_out() !== 64'hD) $display("FAIL gap_bits: got %h want %h", pack_out(), 64'hD);
        else n_pass++;
        n_total++;
        if (idle_strobes != 0) $display("FAIL gap_idle_strobe: got %0d want 0", idle_strobes);
        else n_pass++;
        n_total++;
        if (nsym != 36) $display("FAIL gap_symbols: got %0d want 36", nsym);
        else n_pass++;
    endtask

    task automatic test_restart();
        logic [19:0] ra, rb;
        logic [63:0] exp_v;
        logic [15:0] exp_err;
        ra      = 20'($urandom);
        rb      = 20'($urandom);
        exp_err = ErrCntEn ? 16'd1 : 16'd0;
        clear_mon();
        for (int i = 0; i < 20; i++) send_bit(ra[i], (i == 3) ? 2'b01 : 2'b00, i == 0);
        idle(2);
        n_total++;
        if (err_cnt !== exp_err) $display("FAIL rst_pre_err_cnt: got %h want %h", err_cnt, exp_err);
        else n_pass++;
        // Restart at symbol 20; the sender restarts its encoder at the same point.
        for (int i = 0; i < 20; i++) send_bit(rb[i], 2'b00, i == 0);
        for (int i = 0; i < TbDepth - 1; i++) send_bit(1'b0, 2'b00, 1'b0);
        idle(3);
        exp_v = '0;
        for (int i = 0; i < 6; i++) exp_v[i] = ra[i];
        for (int i = 0; i < 20; i++) exp_v[6 + i] = rb[i];
        n_total++;
        if (mon_q.size() != 26) $display("FAIL rst_count: got %0d want 26", mon_q.size());
        else n_pass++;
        n_total++;
        if (pack_out() !== exp_v) $display("FAIL rst_bits: got %h want %h", pack_out(), exp_v);
        else n_pass++;
        n_total++;
        if (err_cnt !== 16'h0) $display("FAIL rst_err_cnt: got %h want 0000", err_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        clear_mon();
        for (int i = 0; i < 20; i++) send_bit(1'b1, 2'b00, i == 0);
        @(posedge CLK);
        #3;
        n_total++;
        if (out_valid !== 1'b1 || out_bit !== 1'b1)
            $display("FAIL areset_pre: got %b%b want 11", out_valid, out_bit);
        else n_pass++;
        RST_N = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0)
            $display("FAIL areset_out: got %b%b want 00", out_valid, out_bit);
        else n_pass++;
        n_total++;
        if (dut.pm_q[0] !== 6'd0 || dut.pm_q[1] !== 6'd63 || dut.pm_q[2] !== 6'd63
            || dut.pm_q[3] !== 6'd63)
            $display("FAIL areset_pm: got %0d %0d %0d %0d want 0 63 63 63",
                     dut.pm_q[0], dut.pm_q[1], dut.pm_q[2], dut.pm_q[3]);
        else n_pass++;
        clear_mon();
        idle(3);
        n_total++;
        if (mon_q.size() != 0) $display("FAIL areset_no_strobe: got %0d want 0", mon_q.size());
        else n_pass++;
        RST_N = 1'b1;
        idle(1);
        run_ref(-1, 0);
        n_total++;
        if (pack_out() !== 64'hD || mon_q.size() != 22)
            $display("FAIL areset_fresh: got %h/%0d want %h/22", pack_out(), mon_q.size(), 64'hD);
        else n_pass++;
    endtask

    task automatic test_long();
        bit          src[$];
        logic [1:0]  flip;
        int          nerr, bad;
        logic [15:0] exp_err;
        clear_mon();
        nerr = 0;
        for (int i = 0; i < 1500; i++) begin
            src.push_back(1'($urandom));
            flip = 2'b00;
            if (i % 25 == 12) begin
                flip = 2'($urandom_range(3, 1));
                nerr += (flip == 2'b11) ? 2 : 1;
            end
            send_bit(src[i], flip, i == 0);
            if ($urandom_range(9, 0) == 0) idle($urandom_range(3, 1));
        end
        for (int i = 0; i < TbDepth - 1; i++) send_bit(1'b0, 2'b00, 1'b0);
        idle(3);
        bad = 0;
        for (int i = 0; i < mon_q.size() && i < 1500; i++) if (mon_q[i] != src[i]) bad++;
        exp_err = ErrCntEn ? 16'(nerr) : 16'd0;
        n_total++;
        if (mon_q.size() != 1500) $display("FAIL long_count: got %0d want 1500", mon_q.size());
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL long_bit_errors: got %0d want 0", bad);
        else n_pass++;
        n_total++;
        if (idle_strobes != 0) $display("FAIL long_idle_strobe: got %0d want 0", idle_strobes);
        else n_pass++;
        n_total++;
        if (err_cnt !== exp_err) $display("FAIL long_err_cnt: got %0d want %0d", err_cnt, exp_err);
        else n_pass++;
    endtask

    initial begin
        enc_u1 = 1'b0;
        enc_u2 = 1'b0;
        clear_mon();
        test_reset();
        test_clean();
        test_single_error();
        test_gapped();
        test_restart();
        test_async_reset();
        test_long();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
